// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: packs decoded field records into 32-bit words.
// Legality-checked, queued through a 2-entry FIFO, with saturating counters.
module rv32i_inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_illegal,
  input  logic        clr_counts,
  output logic [15:0] enc_count,
  output logic [7:0]  illegal_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] word;
  logic [31:0] inst;
  logic        ok;
  logic        sx11, sx12, sx20;
  logic        shift;
  logic        f7_zero, f7_alt;

  assign sx11    = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign sx12    = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign sx20    = (&in_imm[31:20]) | ~(|in_imm[31:20]);
  assign shift   = (in_funct3[1:0] == 2'b01);
  assign f7_zero = (in_funct7 == 7'h00);
  assign f7_alt  = (in_funct7 == 7'h20);

  always_comb begin
    word = '0;
    ok   = 1'b0;
    unique case (in_opcode)
      OP_LUI, OP_AUIPC: begin
        word = {in_imm[31:12], in_rd, in_opcode};
        ok   = (in_imm[11:0] == 12'h000);
      end
      OP_JAL: begin
        word = {in_imm[20], in_imm[10:1], in_imm[11],
                in_imm[19:12], in_rd, in_opcode};
        ok   = sx20 && !in_imm[0];
      end
      OP_JALR: begin
        word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        ok   = sx11 && (in_funct3 == 3'b000);
      end
      OP_LOAD: begin
        word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        ok   = sx11 && (in_funct3 != 3'b011)
                    && (in_funct3[2:1] != 2'b11);
      end
      OP_IMM: begin
        if (shift) begin
          // shamt lives in imm[4:0]; the upper field comes from funct7
          word = {in_funct7, in_imm[4:0], in_rs1,
                  in_funct3, in_rd, in_opcode};
          ok   = f7_zero || (in_funct3[2] && f7_alt);
        end else begin
          word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          ok   = sx11;
        end
      end
      OP_STORE: begin
        word = {in_imm[11:5], in_rs2, in_rs1,
                in_funct3, in_imm[4:0], in_opcode};
        ok   = sx11 && !in_funct3[2] && (in_funct3 != 3'b011);
      end
      OP_BR: begin
        word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                in_funct3, in_imm[4:1], in_imm[11], in_opcode};
        ok   = sx12 && !in_imm[0] && (in_funct3[2:1] != 2'b01);
      end
      OP_REG: begin
        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        ok   = f7_zero || (f7_alt && ((in_funct3 == 3'b000) ||
                                      (in_funct3 == 3'b101)));
      end
      default: begin
        word = '0;
        ok   = 1'b0;
      end
    endcase
    inst = ok ? word : 32'h0;
  end

  logic [32:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_inst    = out_valid ? mem[rd_ptr][31:0] : 32'h0;
  assign out_illegal = out_valid ? mem[rd_ptr][32] : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= {!ok, inst};
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_count     <= '0;
      illegal_count <= '0;
    end else if (clr_counts) begin
      enc_count     <= '0;
      illegal_count <= '0;
    end else if (push) begin
      if (ok && enc_count != 16'hFFFF)
        enc_count <= enc_count + 16'd1;
      if (!ok && illegal_count != 8'hFF)
        illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder: hand-packed vectors, backpressure,
// streaming with counter saturation, and mid-run reset.
module tb_rv32i_inst_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_illegal;
  logic        clr_counts;
  logic [15:0] enc_count;
  logic [7:0]  illegal_count;

  int total = 0;
  int bad   = 0;
  int exp_enc = 0;
  int exp_ill = 0;

  rv32i_inst_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_illegal(out_illegal),
    .clr_counts(clr_counts), .enc_count(enc_count),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  // one record in, one word out, with out_ready held high
  task automatic xact(input string tag,
                      input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm,
                      input logic [31:0] e_inst, input logic e_ill);
    @(negedge clk);
    set_rec(op, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    #1 chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".inst"}, out_inst, e_inst);
    chk({tag, ".ill"}, 32'(out_illegal), 32'(e_ill));
    if (e_ill) exp_ill++;
    else exp_enc++;
    @(posedge clk);
    #1 chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    clr_counts = 1'b0;
    set_rec('0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.inst", out_inst, 32'h0);
    chk("rst.ill", 32'(out_illegal), 32'd0);
    chk("rst.enc", 32'(enc_count), 32'd0);
    chk("rst.bad", 32'(illegal_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    xact("addi", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,
         32'h00500093, 1'b0);
    chk("addi.enc", 32'(enc_count), 32'd1);
    xact("sub", 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,
         32'h402081B3, 1'b0);
    xact("beq", 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd4,
         32'hFE208EE3, 1'b0);
    xact("lui", 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,
         32'h123452B7, 1'b0);
    xact("jal", 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800,
         32'h001000EF, 1'b0);
    xact("lui_bad", 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345001,
         32'h0, 1'b1);
    chk("lui_bad.cnt", 32'(illegal_count), 32'd1);
    xact("sw", 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,
         32'h0020A423, 1'b0);
    xact("srai", 7'h13, 3'd5, 7'h20, 5'd4, 5'd1, 5'd0, 32'd3,
         32'h4030D213, 1'b0);
    xact("jalr", 7'h67, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF,
         32'hFFF100E7, 1'b0);
    xact("ld_f3", 7'h03, 3'd3, 7'h00, 5'd1, 5'd2, 5'd0, 32'd0,
         32'h0, 1'b1);
    xact("br_f3", 7'h63, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,
         32'h0, 1'b1);
    xact("br_odd", 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd5,
         32'h0, 1'b1);
    xact("reg_f7", 7'h33, 3'd1, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,
         32'h0, 1'b1);
    xact("slli_f7", 7'h13, 3'd1, 7'h20, 5'd3, 5'd1, 5'd0, 32'd2,
         32'h0, 1'b1);
    xact("addi_rng", 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h800,
         32'h0, 1'b1);
    xact("jal_rng", 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h100000,
         32'h0, 1'b1);
    xact("badop", 7'h7F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,
         32'h0, 1'b1);
    chk("dir.enc", 32'(enc_count), 32'(exp_enc));
    chk("dir.bad", 32'(illegal_count), 32'(exp_ill));

    // backpressure: A, B accepted, C held until a slot frees
    @(negedge clk);
    out_ready = 1'b0;
    set_rec(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_rec(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2);
    @(posedge clk);
    #1 chk("bp.full", 32'(in_ready), 32'd0);
    @(negedge clk);
    set_rec(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
    @(posedge clk);
    #1;
    chk("bp.hold_rdy", 32'(in_ready), 32'd0);
    chk("bp.hold_A", out_inst, 32'h00100093);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.B", out_inst, 32'h00200093);
    chk("bp.rdy_up", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.C", out_inst, 32'h00300093);
    chk("bp.C_vld", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 chk("bp.empty", 32'(out_valid), 32'd0);

    // streaming 100 records, then counter saturation and clear
    @(negedge clk);
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    set_rec(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("st.vld", 32'(out_valid), 32'd1);
      chk("st.rdy", 32'(in_ready), 32'd1);
      if (i % 25 == 7) chk("st.inst", out_inst, 32'h00500093);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("st.enc100", 32'(enc_count), 32'd100);
    @(negedge clk);
    in_valid = 1'b1;
    repeat (70000) @(posedge clk);
    #1 chk("st.sat", 32'(enc_count), 32'hFFFF);
    @(negedge clk);
    clr_counts = 1'b1;
    @(posedge clk);
    #1;
    chk("clr.enc", 32'(enc_count), 32'd0);
    chk("clr.bad", 32'(illegal_count), 32'd0);
    @(negedge clk);
    clr_counts = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);

    // reset with two words queued
    @(negedge clk);
    out_ready = 1'b0;
    set_rec(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rr.full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rr.vld", 32'(out_valid), 32'd0);
    chk("rr.rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("rr.stale", 32'(out_valid), 32'd0);
    end
    chk("rr.enc", 32'(enc_count), 32'd0);
    chk("rr.bad", 32'(illegal_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_inst_encoder.md
# rv32i_inst_encoder

Streaming RV32I instruction encoder: accepts decoded instruction records (opcode, funct3, funct7, register indices, full-width immediate) and emits 32-bit RV32I instruction words. It performs the inverse of the control-word decode path. It sits between the self-test program generator and the instruction-memory model, so directed and random programs can be built from fields rather than hand-packed words. It has a valid/ready handshake on both sides, a 2-entry output FIFO, legality checking and saturating statistics counters.

## Interface
- No parameters; widths fixed by RV32I.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input record valid
- in_ready  out  1  encoder can accept a record
- in_opcode  in  7  rv32i_opcode value
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R-type and I-type shifts only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  immediate as the full signed value (U-type: the final 32-bit value)
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- out_illegal  out  1  record failed legality; out_inst is 0
- clr_counts  in  1  synchronous clear of both counters
- enc_count  out  16  legal records accepted, saturates at 0xFFFF
- illegal_count  out  8  illegal records accepted, saturates at 0xFF

## Operation
- Accept occurs when in_valid && in_ready. The record is encoded combinationally and pushed into the FIFO with its illegal flag.
- Emit occurs when out_valid && out_ready. The FIFO head is popped.
- Format selection by opcode:
  - lui / auipc: U
  - jal: J
  - jalr, load, imm: I
  - store: S
  - br: B
  - reg: R
- Any other opcode is illegal.
- Bit placement:
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] opcode[6:0].
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12].
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12].
  - Fields not used by the format are driven 0 (e.g. rs1/rs2 for U/J, rd for S/B).
- I-type shifts (funct3 001/101): bits [31:25] come from in_funct7, and shamt = in_imm[4:0] goes to [24:20].
- Legality checks; any failure sets the illegal flag:
  - I/S immediates must sign-extend from bit 11; B from bit 12; J from bit 20.
  - B/J immediates require imm[0]=0.
  - U requires imm[11:0]=0.
  - load funct3 ∈ {000,001,010,100,101}; store funct3 ∈ {000,001,010}.
  - br funct3 ∉ {010,011}; jalr funct3 = 000.
  - reg: funct7 ∈ {0x00,0x20}, and 0x20 only with funct3 000 or 101.
  - imm shifts: slli requires funct7=0x00; srli/srai require funct7 ∈ {0x00,0x20}; imm[11:5] is ignored.
- Counters:
  - An accepted legal record increments enc_count; an accepted illegal record increments illegal_count.
  - Both counters saturate.
  - clr_counts zeroes both and takes priority over a same-cycle increment.

## Timing
- Reset (rst=0) state, asynchronous:
  - FIFO empty, so out_valid=0 and in_ready=1.
  - out_inst=0, out_illegal=0.
  - Both counters 0.
- Reset asserted mid-operation flushes all queued words with no emission.
- Latency: a record accepted in cycle N drives out_valid in N+1. No combinational in→out path.
- in_ready = (count < 2). It depends only on registered state: no combinational dependence on out_ready, and no push when full even if popping that cycle.
- Simultaneous push and pop at count 1: count stays 1, and the new word becomes head in the next cycle.
- At count 2 with a pop: count becomes 1, and in_ready rises in the next cycle.
- out_inst and out_illegal hold stable while out_valid && !out_ready.
- Ordering is strict FIFO; illegal records occupy slots like legal ones.

## Test plan
- addi x1,x0,5 (opcode 0010011, f3 000, rd 1, imm 5) -> out_inst 0x00500093 one cycle after accept, out_illegal 0, enc_count 1.
- sub x3,x1,x2 (opcode 0110011, f7 0x20) -> 0x402081B3. beq x1,x2,imm −4 -> 0xFE208EE3.
- lui x5,imm 0x12345000 -> 0x123452B7. jal x1,imm 0x800 -> 0x001000EF. lui with imm 0x12345001 -> out_illegal 1, out_inst 0, illegal_count 1.
- out_ready=0, three back-to-back valid records -> first two accepted, in_ready=0 from the cycle after the second, third held. Release out_ready -> all three emerge in order, with no loss or duplication.
- Continuous in_valid/out_ready=1 for 100 records -> one word per cycle after the first, enc_count 100. Then 70000 more -> enc_count 0xFFFF. clr_counts with a concurrent accept -> 0.
- Assert rst with 2 words queued -> out_valid 0 and in_ready 1 immediately; after release, no stale words appear and counters read 0.
